// File: rtl/sm_addsub_seq.sv
// -----------------------------------------------------------------------------
// sm_addsub_seq
//   Multi-cycle sign-magnitude adder/subtractor. A request (A, B, op) is
//   captured when in_valid meets in_ready. The operands are then converted to
//   two's complement, added, and converted back to sign-magnitude over three
//   one-cycle steps. The result is held in DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept a request (IDLE only)
//   A, B       operands, sign-magnitude, bit W = sign (1 = negative)
//   op         0 = A+B, 1 = A-B
//   out_valid  result available (DONE only)
//   out_ready  consumer takes result
//   R          result, sign-magnitude, bit W = sign, never negative zero
//   ovf        result magnitude needs more than W bits
//   c          {Ac, Bc}: which operands were complemented for this operation
// -----------------------------------------------------------------------------
module sm_addsub_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   A,
    input  logic [W:0]   B,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   R,
    output logic         ovf,
    output logic [1:0]   c
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ADD   = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Magnitude widened by two bits and negated on request; the extra bits
    // hold the sign and the carry out of a W-bit magnitude sum.
    function automatic logic signed [W+1:0] sm_to_tc(input logic [W-1:0] mag,
                                                     input logic neg);
        logic signed [W+1:0] ext;
        ext = {2'b00, mag};
        return neg ? -ext : ext;
    endfunction

    // Absolute value of the sum; cannot overflow because |S| < 2^(W+1).
    function automatic logic [W+1:0] tc_abs(input logic signed [W+1:0] v);
        return v[W+1] ? -v : v;
    endfunction

    state_t              state_r, state_s;
    logic                in_ready_r, out_valid_r;
    logic                accept_s;
    logic [W:0]          a_r, b_r;
    logic                op_r;
    logic                ac_s, bc_s, ac_r, bc_r;
    logic signed [W+1:0] ax_s, bx_s, ax_r, bx_r;
    logic signed [W+1:0] sum_s, s_r;
    logic [W+1:0]        abs_s;
    logic [W-1:0]        mag_s;
    logic                sign_s, ovf_s;
    logic [W:0]          r_r;
    logic                ovf_r;
    logic [1:0]          c_r;

    assign accept_s  = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign R         = r_r;
    assign ovf       = ovf_r;
    assign c         = c_r;

    // Next-state logic: fixed three-step pipeline, then hold until consumed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = SETUP;
                else          state_s = IDLE;
            end
            SETUP:   state_s = ADD;
            ADD:     state_s = FIX;
            FIX:     state_s = DONE;
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath combinational steps for SETUP and FIX.
    always_comb begin
        ac_s   = a_r[W];
        bc_s   = b_r[W] ^ op_r;
        ax_s   = sm_to_tc(a_r[W-1:0], ac_s);
        bx_s   = sm_to_tc(b_r[W-1:0], bc_s);
        sum_s  = ax_r + bx_r;
        abs_s  = tc_abs(s_r);
        mag_s  = abs_s[W-1:0];
        ovf_s  = abs_s[W] | abs_s[W+1];
        // A zero magnitude is always reported as +0, even on overflow.
        sign_s = s_r[W+1] & (mag_s != {W{1'b0}});
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= {(W+1){1'b0}};
            b_r  <= {(W+1){1'b0}};
            op_r <= 1'b0;
        end else if (accept_s) begin
            a_r  <= A;
            b_r  <= B;
            op_r <= op;
        end
    end

    // SETUP: complement flags and two's-complement operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_r <= 1'b0;
            bc_r <= 1'b0;
            ax_r <= {(W+2){1'b0}};
            bx_r <= {(W+2){1'b0}};
        end else if (state_r == SETUP) begin
            ac_r <= ac_s;
            bc_r <= bc_s;
            ax_r <= ax_s;
            bx_r <= bx_s;
        end
    end

    // ADD: full-width sum, no truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r <= {(W+2){1'b0}};
        end else if (state_r == ADD) begin
            s_r <= sum_s;
        end
    end

    // FIX: back to sign-magnitude; outputs change only on the FIX->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r   <= {(W+1){1'b0}};
            ovf_r <= 1'b0;
            c_r   <= 2'b00;
        end else if (state_r == FIX) begin
            r_r   <= {sign_s, mag_s};
            ovf_r <= ovf_s;
            c_r   <= {ac_r, bc_r};
        end
    end

endmodule

// File: tb/tb_sm_addsub_seq.sv
module tb_sm_addsub_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   A, B;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   R;
    logic         ovf;
    logic [1:0]   c;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [W:0] a;
        logic [W:0] b;
        logic       op;
        logic [W:0] r;
        logic       ovf;
        logic [1:0] c;
    } vec_t;

    typedef struct {
        logic [W:0] r;
        logic       ovf;
        logic [1:0] c;
    } exp_t;

    vec_t tbl [9];

    sm_addsub_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .ovf       (ovf),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: signed integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W:0] a, input logic [W:0] b, input logic o);
        longint av, bv, s, m;
        logic   bneg;
        exp_t   e;
        bneg = b[W] ^ o;
        av = longint'({32'd0, a[W-1:0]});
        bv = longint'({32'd0, b[W-1:0]});
        if (a[W]) av = -av;
        if (bneg) bv = -bv;
        s = av + bv;
        m = (s < 0) ? -s : s;
        e.ovf        = (m >= (longint'(1) << W));
        e.r[W-1:0]   = m[W-1:0];
        e.r[W]       = (s < 0) && (m[W-1:0] != 32'd0);
        e.c          = {a[W], bneg};
        return e;
    endfunction

    // Issue one request, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [W:0] a, input logic [W:0] b,
                          input logic o, input logic [W:0] er, input logic eo,
                          input logic [1:0] ec);
        int n;
        @(negedge clk);
        in_valid = 1'b1; A = a; B = b; op = o; out_ready = 1'b0;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 64'(n), 64'd3);
        chk({tag, ".R"},   64'(R),   64'(er));
        chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
        chk({tag, ".c"},   64'(c),   64'(ec));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".released"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        exp_t       e;
        logic [W:0] a, b;
        logic       o;
        logic [W:0] hold_r;
        logic       hold_o;
        logic [1:0] hold_c;
        int         n;

        tbl[0] = '{33'h0_00000005, 33'h0_00000003, 1'b0, 33'h0_00000008, 1'b0, 2'b00};
        tbl[1] = '{33'h0_00000003, 33'h0_00000005, 1'b1, 33'h1_00000002, 1'b0, 2'b01};
        tbl[2] = '{33'h1_00000007, 33'h0_00000007, 1'b0, 33'h0_00000000, 1'b0, 2'b10};
        tbl[3] = '{33'h0_FFFFFFFF, 33'h1_00000001, 1'b1, 33'h0_00000000, 1'b1, 2'b00};
        tbl[4] = '{33'h1_FFFFFFFF, 33'h1_00000001, 1'b0, 33'h0_00000000, 1'b1, 2'b11};
        tbl[5] = '{33'h1_00000000, 33'h1_00000000, 1'b0, 33'h0_00000000, 1'b0, 2'b11};
        tbl[6] = '{33'h0_80000000, 33'h0_80000001, 1'b0, 33'h0_00000001, 1'b1, 2'b00};
        tbl[7] = '{33'h1_00000005, 33'h0_00000003, 1'b1, 33'h1_00000008, 1'b0, 2'b11};
        tbl[8] = '{33'h1_00000002, 33'h1_00000009, 1'b1, 33'h0_00000007, 1'b0, 2'b10};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; op = 1'b0;
        #12;
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.R",         64'(R),         64'd0);
        chk("rst.ovf_c",     64'({ovf, c}),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
                   tbl[i].r, tbl[i].ovf, tbl[i].c);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = {$urandom_range(0, 1) == 1, 32'($urandom)};
            b = {$urandom_range(0, 1) == 1, 32'($urandom)};
            case ($urandom_range(0, 2))
                0: a[W-1:0] = 32'($urandom_range(0, 15));
                1: a[W-1:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: ;
            endcase
            if (($urandom & 1) == 1) b[W-1:0] = a[W-1:0];
            o = $urandom_range(0, 1) == 1;
            e = model(a, b, o);
            run_op($sformatf("rnd%0d", i), a, b, o, e.r, e.ovf, e.c);
        end

        // Backpressure: result held, no accept while DONE.
        @(negedge clk);
        in_valid = 1'b1; A = 33'h0_00000010; B = 33'h1_00000004; op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A = 33'h0_00000100; B = 33'h0_00000001; op = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("bp.latency", 64'(n), 64'd3);
        hold_r = R; hold_o = ovf; hold_c = c;
        chk("bp.R", 64'(R), 64'h0_0000000C);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp.hold%0d", k), 64'({out_valid, in_ready, R, ovf, c}),
                64'({1'b1, 1'b0, hold_r, hold_o, hold_c}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.to_idle", 64'({out_valid, in_ready}), 64'b01);
        chk("bp.R_after", 64'(R), 64'(hold_r));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.accept2", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = model(33'h0_00000100, 33'h0_00000001, 1'b1);
        chk("bp2.latency", 64'(n), 64'd3);
        chk("bp2.R", 64'(R), 64'(e.r));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during ADD aborts the operation and clears outputs at once.
        run_op("pre_abort", 33'h0_00000005, 33'h0_00000003, 1'b0, 33'h0_00000008, 1'b0, 2'b00);
        @(negedge clk);
        in_valid = 1'b1; A = 33'h1_00000009; B = 33'h0_00000002; op = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'd0);
        chk("abort.R",         64'(R),         64'd0);
        chk("abort.ovf_c",     64'({ovf, c}),  64'd0);
        chk("abort.in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.rel_ready", 64'(in_ready), 64'd1);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort.no_valid", 64'(n), 64'd0);
        e = model(33'h1_00000009, 33'h0_00000002, 1'b1);
        run_op("post_abort", 33'h1_00000009, 33'h0_00000002, 1'b1, e.r, e.ovf, e.c);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm_addsub_seq.md
SM_ADDSUB_SEQ -- requirements
Module: sm_addsub_seq

Interface
REQ-001 SHALL have parameter W, default 32, magnitude width in bits (operand/result width W+1, MSB = sign).
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port A  input  W+1  operand A, sign-magnitude, A[W] = sign (1 = negative).
REQ-007 SHALL have port B  input  W+1  operand B, sign-magnitude, B[W] = sign.
REQ-008 SHALL have port op  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port R  output  W+1  result, sign-magnitude, R[W] = sign.
REQ-012 SHALL have port ovf  output  1  result magnitude exceeded W bits.
REQ-013 SHALL have port c  output  2  complement flags {Ac, Bc} of the accepted operation.

Function
REQ-014 SHALL use FSM states IDLE, SETUP, ADD, FIX, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept occurs on a rising edge with in_valid & in_ready; A, B, op captured at that edge.
REQ-016 SHALL transition IDLE->SETUP on accept; SETUP->ADD, ADD->FIX, FIX->DONE unconditionally, one cycle each.
REQ-017 SETUP SHALL compute Ac = A[W], Bc = B[W] ^ op, and register signed W+2-bit operands Ax = Ac ? -A[W-1:0] : A[W-1:0], Bx = Bc ? -B[W-1:0] : B[W-1:0].
REQ-018 ADD SHALL register S = Ax + Bx, W+2 bits signed, no truncation.
REQ-019 FIX SHALL register R[W] = S[W+1], R[W-1:0] = low W bits of |S|, ovf = (|S| >= 2^W).
REQ-020 SHALL force R[W] = 0 whenever R[W-1:0] == 0 (no negative zero output), including when ovf = 1.
REQ-021 SHALL treat negative-zero inputs (sign 1, magnitude 0) as zero.
REQ-022 SHALL assert out_valid only in DONE; first cycle of out_valid is the cycle after the 3rd rising edge following the accept edge.
REQ-023 SHALL update R, ovf, c only on the FIX->DONE edge; they SHALL hold stable while in DONE and after leaving it until the next FIX.
REQ-024 DONE SHALL go to IDLE on an edge with out_ready = 1; otherwise remain in DONE (backpressure, no result loss).
REQ-025 SHALL ignore in_valid in every state except IDLE; no accept in the same cycle as the DONE->IDLE transition.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid = 0, R = 0, ovf = 0, c = 00, internal Ax/Bx/S = 0, independent of clk.
REQ-027 in_ready SHALL be 1 while in reset and in the first cycle after release.
REQ-028 reset asserted in any non-IDLE state SHALL abort the operation; no out_valid for it after release.

Verification
REQ-029 A=0x0_00000005, B=0x0_00000003, op=0 -> R=0x0_00000008, c=00, ovf=0, out_valid 3 edges after accept.
REQ-030 A=0x0_00000003, B=0x0_00000005, op=1 -> R=0x1_00000002, c=01, ovf=0.
REQ-031 A=0x1_00000007, B=0x0_00000007, op=0 -> R=0x0_00000000 (sign forced 0), c=10, ovf=0.
REQ-032 A=0x0_FFFFFFFF, B=0x1_00000001, op=1 -> c=00, ovf=1, R=0x0_00000000; A=0x1_FFFFFFFF, B=0x1_00000001, op=0 -> c=11, ovf=1, R=0x0_00000000.
REQ-033 out_ready held 0 for 4 cycles in DONE with in_valid=1 -> R/ovf/c stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge, then new request accepted.
REQ-034 rst_n pulsed low during ADD -> out_valid, R, ovf, c go 0 without a clock edge; after release in_ready=1, out_valid stays 0 until a new request completes.
